// File: rtl/glb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : glb_pkg
// Description : Shared types and helpers for the global PE bus caster.
//               Contents: stream-select and FSM state enums, the ID/TAG
//               width helper and the broadcast tag constant.
// Revision    : 1.0 - initial release
// ============================================================================
package glb_pkg;

    // Which per-stream FIFO a bus word is steered into.
    typedef enum logic [1:0] {
        SEL_IFMAP = 2'd0,
        SEL_FLTR  = 2'd1,
        SEL_PSUM  = 2'd2,
        SEL_RSVD  = 2'd3
    } sel_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    // ID/TAG width: one bit wider than a column index, so the all-ones
    // value never collides with a real PE ID.
    function automatic int idw(input int num_col);
        return $clog2(num_col) + 1;
    endfunction

    // Broadcast tag; the low idw() bits are used.
    localparam logic [7:0] c_bcast_tag = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/glb_pe_caster_if.sv
`default_nettype none
// ============================================================================
// Module      : glb_pe_caster_if
// Description : Bus/PE-side bundle for glb_pe_caster.
//               master : upstream bus + PE consumer (drives config, bus word,
//                        PE readies and pe_fltr_clr)
//               slave  : the caster (drives bus_rdy, the three PE streams,
//                        fltr_row_full and busy)
// Revision    : 1.0 - initial release
// ============================================================================
interface glb_pe_caster_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4
);
    localparam int IDW = glb_pkg::idw(NUM_COL);

    logic                    caster_en;
    logic [IDW-1:0]          cfg_id;
    logic [7:0]              kernel_size;
    logic                    bus_valid;
    logic [1:0]              bus_sel;
    logic [IDW-1:0]          bus_tag;
    logic [DATA_WIDTH-1:0]   bus_ifmap_data;
    logic [DATA_WIDTH-1:0]   bus_fltr_data;
    logic [2*DATA_WIDTH-1:0] bus_psum_data;
    logic                    bus_rdy;

    logic [DATA_WIDTH-1:0]   pe_ifmap_data;
    logic                    pe_ifmap_valid;
    logic                    pe_ifmap_ready;
    logic [DATA_WIDTH-1:0]   pe_fltr_data;
    logic                    pe_fltr_valid;
    logic                    pe_fltr_ready;
    logic [2*DATA_WIDTH-1:0] pe_psum_data;
    logic                    pe_psum_valid;
    logic                    pe_psum_ready;
    logic                    pe_fltr_clr;
    logic                    fltr_row_full;
    logic                    busy;

    modport master (
        output caster_en, cfg_id, kernel_size,
        output bus_valid, bus_sel, bus_tag,
        output bus_ifmap_data, bus_fltr_data, bus_psum_data,
        input  bus_rdy,
        input  pe_ifmap_data, pe_ifmap_valid, output pe_ifmap_ready,
        input  pe_fltr_data,  pe_fltr_valid,  output pe_fltr_ready,
        input  pe_psum_data,  pe_psum_valid,  output pe_psum_ready,
        output pe_fltr_clr,
        input  fltr_row_full, busy
    );

    modport slave (
        input  caster_en, cfg_id, kernel_size,
        input  bus_valid, bus_sel, bus_tag,
        input  bus_ifmap_data, bus_fltr_data, bus_psum_data,
        output bus_rdy,
        output pe_ifmap_data, pe_ifmap_valid, input pe_ifmap_ready,
        output pe_fltr_data,  pe_fltr_valid,  input pe_fltr_ready,
        output pe_psum_data,  pe_psum_valid,  input pe_psum_ready,
        input  pe_fltr_clr,
        output fltr_row_full, busy
    );
endinterface
`default_nettype wire

// File: rtl/caster_fifo.sv
`default_nettype none
// ============================================================================
// Module      : caster_fifo
// Description : Synchronous FIFO, WIDTH x DEPTH (DEPTH power of two, >=2).
//               Ports: clk, rstn (async, active-low), push/push_data,
//               pop, head (0 when empty), full, empty.
//               Pushes when full and pops when empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module caster_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);
    localparam int c_aw = $clog2(DEPTH);

    // Extra MSB distinguishes full from empty when the indices coincide.
    logic [c_aw:0]      r_wptr;
    logic [c_aw:0]      r_rptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_push;
    logic               w_pop;

    assign empty  = (r_wptr == r_rptr);
    assign full   = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                    (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    // Forcing 0 when empty keeps the data output clean without resetting RAM.
    assign head   = empty ? '0 : r_mem[r_rptr[c_aw-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[c_aw-1:0]] <= push_data;
    end
endmodule
`default_nettype wire

// File: rtl/glb_pe_caster.sv
`default_nettype none
// ============================================================================
// Module      : glb_pe_caster
// Description : Per-PE multicast caster. Accepts global-bus words addressed
//               to cfg_id (or broadcast) and steers them into ifmap, filter
//               and psum FIFOs that feed the PE over valid/ready streams.
//               Filter loading is limited to kernel_size words per row until
//               pe_fltr_clr re-arms it. Dropping caster_en drains the FIFOs.
//               Ports: clk, rstn (async, active-low), bif (slave modport).
// Revision    : 1.0 - initial release
// ============================================================================
module glb_pe_caster #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input wire logic        clk,
    input wire logic        rstn,
    glb_pe_caster_if.slave  bif
);
    import glb_pkg::*;

    localparam int c_idw = idw(NUM_COL);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [7:0]  r_ks;
    logic [7:0]  r_fltr_cnt;
    sel_e        w_sel;
    logic        w_tag_match;
    logic        w_accept;
    logic        w_row_full;
    logic        w_if_full, w_fl_full, w_ps_full;
    logic        w_if_empty, w_fl_empty, w_ps_empty;
    logic        w_push_if, w_push_fl, w_push_ps;

    assign w_sel       = sel_e'(bif.bus_sel);
    assign w_tag_match = (bif.bus_tag == bif.cfg_id) ||
                         (bif.bus_tag == c_bcast_tag[c_idw-1:0]);
    // ks_q == 0 means "no row limit".
    assign w_row_full  = (r_ks != 8'd0) && (r_fltr_cnt == r_ks);

    // Ready depends only on state, selected stream and registered full flags,
    // so it never combinationally follows bus_valid/bus_tag or a PE pop.
    always_comb begin
        bif.bus_rdy = 1'b0;
        if (r_state == ACTIVE) begin
            case (w_sel)
                SEL_IFMAP: bif.bus_rdy = !w_if_full;
                SEL_FLTR:  bif.bus_rdy = !w_fl_full && !w_row_full;
                SEL_PSUM:  bif.bus_rdy = !w_ps_full;
                default:   bif.bus_rdy = 1'b0;
            endcase
        end
    end

    assign w_accept  = bif.bus_valid && w_tag_match && bif.bus_rdy;
    assign w_push_if = w_accept && (w_sel == SEL_IFMAP);
    assign w_push_fl = w_accept && (w_sel == SEL_FLTR);
    assign w_push_ps = w_accept && (w_sel == SEL_PSUM);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bif.caster_en)  w_state_nxt = ACTIVE;
            ACTIVE:  if (!bif.caster_en) w_state_nxt = DRAIN;
            // caster_en is ignored here; the drain always completes first.
            DRAIN:   if (w_if_empty && w_fl_empty && w_ps_empty)
                         w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_ks       <= 8'd0;
            r_fltr_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && bif.caster_en) begin
                r_ks       <= bif.kernel_size;
                r_fltr_cnt <= 8'd0;
            end else if (bif.pe_fltr_clr) begin
                // Clear wins over a same-cycle push; the word is still stored.
                r_fltr_cnt <= 8'd0;
            end else if (w_push_fl) begin
                r_fltr_cnt <= r_fltr_cnt + 8'd1;
            end
        end
    end

    assign bif.fltr_row_full  = w_row_full;
    assign bif.busy           = (r_state != IDLE);
    assign bif.pe_ifmap_valid = !w_if_empty;
    assign bif.pe_fltr_valid  = !w_fl_empty;
    assign bif.pe_psum_valid  = !w_ps_empty;

    caster_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_ifmap (
        .clk(clk), .rstn(rstn),
        .push(w_push_if), .push_data(bif.bus_ifmap_data),
        .pop(bif.pe_ifmap_ready), .head(bif.pe_ifmap_data),
        .full(w_if_full), .empty(w_if_empty)
    );

    caster_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_fltr (
        .clk(clk), .rstn(rstn),
        .push(w_push_fl), .push_data(bif.bus_fltr_data),
        .pop(bif.pe_fltr_ready), .head(bif.pe_fltr_data),
        .full(w_fl_full), .empty(w_fl_empty)
    );

    caster_fifo #(.WIDTH(2*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_psum (
        .clk(clk), .rstn(rstn),
        .push(w_push_ps), .push_data(bif.bus_psum_data),
        .pop(bif.pe_psum_ready), .head(bif.pe_psum_data),
        .full(w_ps_full), .empty(w_ps_empty)
    );
endmodule
`default_nettype wire

// File: tb/tb_glb_pe_caster.sv
`default_nettype none
// ============================================================================
// Module      : tb_glb_pe_caster
// Description : Self-checking bench for glb_pe_caster: directed scenarios
//               plus randomized traffic against a queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_glb_pe_caster;
    import glb_pkg::*;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int FD = 4;
    localparam int IW = idw(NC);

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    glb_pe_caster_if #(.DATA_WIDTH(DW), .NUM_COL(NC)) gbus ();

    glb_pe_caster #(.DATA_WIDTH(DW), .NUM_COL(NC), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rstn(rstn), .bif(gbus)
    );

    int total = 0;
    int bad   = 0;

    // Reference: 0 idle, 1 active, 2 drain; FIFOs as queues.
    int          m_state;
    logic [7:0]  m_ks, m_cnt;
    logic [31:0] q_if[$], q_fl[$], q_ps[$];

    function automatic bit m_row_full();
        return (m_ks != 8'd0) && (m_cnt == m_ks);
    endfunction

    function automatic bit m_rdy();
        if (m_state != 1) return 1'b0;
        case (gbus.bus_sel)
            2'd0:    return q_if.size() < FD;
            2'd1:    return (q_fl.size() < FD) && !m_row_full();
            2'd2:    return q_ps.size() < FD;
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle_inputs();
        gbus.caster_en = 0; gbus.cfg_id = '0; gbus.kernel_size = 0;
        gbus.bus_valid = 0; gbus.bus_sel = 0; gbus.bus_tag = '0;
        gbus.bus_ifmap_data = 0; gbus.bus_fltr_data = 0; gbus.bus_psum_data = 0;
        gbus.pe_ifmap_ready = 0; gbus.pe_fltr_ready = 0; gbus.pe_psum_ready = 0;
        gbus.pe_fltr_clr = 0;
    endtask

    task automatic model_clear();
        m_state = 0; m_ks = 0; m_cnt = 0;
        q_if.delete(); q_fl.delete(); q_ps.delete();
    endtask

    // One clock edge; the reference advances using the inputs seen at it.
    task automatic tick();
        bit acc, pi, pf, pp, empty_all, tm;
        int nst;
        logic [7:0] nks, ncnt;
        logic [1:0] sel;
        logic [31:0] d;
        tm  = (gbus.bus_tag == gbus.cfg_id) || (gbus.bus_tag == {IW{1'b1}});
        acc = m_rdy() && gbus.bus_valid && tm;
        sel = gbus.bus_sel;
        d   = (sel == 2'd0) ? {16'h0, gbus.bus_ifmap_data} :
              (sel == 2'd1) ? {16'h0, gbus.bus_fltr_data} : gbus.bus_psum_data;
        pi = gbus.pe_ifmap_ready && q_if.size() > 0;
        pf = gbus.pe_fltr_ready  && q_fl.size() > 0;
        pp = gbus.pe_psum_ready  && q_ps.size() > 0;
        empty_all = (q_if.size() == 0) && (q_fl.size() == 0) && (q_ps.size() == 0);
        nst = m_state; nks = m_ks; ncnt = m_cnt;
        if (m_state == 0 && gbus.caster_en) begin
            nst = 1; nks = gbus.kernel_size; ncnt = 0;
        end else begin
            if (m_state == 1 && !gbus.caster_en) nst = 2;
            if (m_state == 2 && empty_all) nst = 0;
            if (gbus.pe_fltr_clr) ncnt = 0;
            else if (acc && sel == 2'd1) ncnt = m_cnt + 8'd1;
        end
        @(posedge clk);
        #1;
        if (pi) void'(q_if.pop_front());
        if (pf) void'(q_fl.pop_front());
        if (pp) void'(q_ps.pop_front());
        if (acc) begin
            if (sel == 2'd0) q_if.push_back(d);
            else if (sel == 2'd1) q_fl.push_back(d);
            else q_ps.push_back(d);
        end
        m_state = nst; m_ks = nks; m_cnt = ncnt;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 0;
        model_clear();
        #12;
        @(negedge clk);
        rstn = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input logic [IW-1:0] id, input logic [7:0] ks);
        gbus.cfg_id = id; gbus.kernel_size = ks; gbus.caster_en = 1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        gbus.caster_en = 1; gbus.bus_valid = 1;
        rstn = 0;
        #3;
        total++; if (gbus.bus_rdy !== 1'b0) begin bad++; $display("FAIL rst_rdy: got %b want 0", gbus.bus_rdy); end
        total++; if (gbus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", gbus.busy); end
        total++; if ({gbus.pe_ifmap_valid, gbus.pe_fltr_valid, gbus.pe_psum_valid} !== 3'b000) begin
            bad++; $display("FAIL rst_valids: got %b want 000", {gbus.pe_ifmap_valid, gbus.pe_fltr_valid, gbus.pe_psum_valid}); end
        total++; if (gbus.pe_ifmap_data !== 16'h0 || gbus.pe_fltr_data !== 16'h0 || gbus.pe_psum_data !== 32'h0) begin
            bad++; $display("FAIL rst_data: got %h/%h/%h want 0", gbus.pe_ifmap_data, gbus.pe_fltr_data, gbus.pe_psum_data); end
        total++; if (gbus.fltr_row_full !== 1'b0) begin bad++; $display("FAIL rst_rowfull: got %b want 0", gbus.fltr_row_full); end
    endtask

    task automatic test_tag_filter();
        do_reset();
        gbus.cfg_id = 3'd2; gbus.caster_en = 1;
        #1;
        total++; if (gbus.busy !== 1'b0) begin bad++; $display("FAIL busy_pre: got %b want 0", gbus.busy); end
        tick();
        total++; if (gbus.busy !== 1'b1) begin bad++; $display("FAIL busy_rise: got %b want 1", gbus.busy); end
        gbus.bus_valid = 1; gbus.bus_sel = 2'd0; gbus.bus_tag = 3'd1; gbus.bus_ifmap_data = 16'h1234;
        #1;
        total++; if (gbus.bus_rdy !== 1'b1) begin bad++; $display("FAIL tag_rdy_indep: got %b want 1", gbus.bus_rdy); end
        tick();
        total++; if (gbus.pe_ifmap_valid !== 1'b0) begin bad++; $display("FAIL tag_mismatch: got %b want 0", gbus.pe_ifmap_valid); end
        gbus.bus_tag = 3'd2;
        tick();
        gbus.bus_valid = 0;
        total++; if (gbus.pe_ifmap_valid !== 1'b1 || gbus.pe_ifmap_data !== 16'h1234) begin
            bad++; $display("FAIL tag_match: got v=%b d=%h want v=1 d=1234", gbus.pe_ifmap_valid, gbus.pe_ifmap_data); end
        gbus.pe_ifmap_ready = 1;
        tick();
        total++; if (gbus.pe_ifmap_valid !== 1'b0) begin bad++; $display("FAIL tag_single: got %b want 0", gbus.pe_ifmap_valid); end
    endtask

    task automatic test_broadcast();
        do_reset();
        start_session(3'd1, 8'd0);
        gbus.bus_valid = 1; gbus.bus_sel = 2'd2; gbus.bus_tag = 3'd7; gbus.bus_psum_data = 32'hDEADBEEF;
        tick();
        gbus.bus_valid = 0;
        total++; if (gbus.pe_psum_valid !== 1'b1 || gbus.pe_psum_data !== 32'hDEADBEEF) begin
            bad++; $display("FAIL bcast_psum: got v=%b d=%h want v=1 d=deadbeef", gbus.pe_psum_valid, gbus.pe_psum_data); end
    endtask

    task automatic test_filter_row();
        logic [15:0] exp_seq [4];
        exp_seq = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
        do_reset();
        start_session(3'd0, 8'd3);
        gbus.bus_valid = 1; gbus.bus_sel = 2'd1; gbus.bus_tag = 3'd0;
        for (int i = 0; i < 4; i++) begin
            gbus.bus_fltr_data = 16'h0010 + 16'(i);
            #1;
            total++; if (gbus.bus_rdy !== (i < 3)) begin bad++; $display("FAIL row_rdy%0d: got %b want %b", i, gbus.bus_rdy, (i < 3)); end
            if (i < 3) tick();
        end
        total++; if (gbus.fltr_row_full !== 1'b1) begin bad++; $display("FAIL row_full: got %b want 1", gbus.fltr_row_full); end
        gbus.pe_fltr_clr = 1;
        tick();
        gbus.pe_fltr_clr = 0;
        #1;
        total++; if (gbus.fltr_row_full !== 1'b0 || gbus.bus_rdy !== 1'b1) begin
            bad++; $display("FAIL row_clr: got full=%b rdy=%b want 0/1", gbus.fltr_row_full, gbus.bus_rdy); end
        tick();
        gbus.bus_valid = 0;
        gbus.pe_fltr_ready = 1;
        for (int i = 0; i < 4; i++) begin
            total++; if (gbus.pe_fltr_data !== exp_seq[i]) begin bad++; $display("FAIL row_order%0d: got %h want %h", i, gbus.pe_fltr_data, exp_seq[i]); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        start_session(3'd3, 8'd0);
        gbus.bus_valid = 1; gbus.bus_sel = 2'd0; gbus.bus_tag = 3'd3;
        for (int i = 0; i < 5; i++) begin
            gbus.bus_ifmap_data = 16'(i + 1);
            #1;
            total++; if (gbus.bus_rdy !== (i < 4)) begin bad++; $display("FAIL bp_rdy%0d: got %b want %b", i, gbus.bus_rdy, (i < 4)); end
            if (i < 4) tick();
        end
        gbus.pe_ifmap_ready = 1;
        #1;
        total++; if (gbus.bus_rdy !== 1'b0) begin bad++; $display("FAIL bp_regfull: got %b want 0", gbus.bus_rdy); end
        for (int k = 0; k < 5; k++) begin
            total++; if (gbus.pe_ifmap_data !== 16'(k + 1)) begin bad++; $display("FAIL bp_order%0d: got %h want %h", k, gbus.pe_ifmap_data, k + 1); end
            if (k == 1) begin
                total++; if (gbus.bus_rdy !== 1'b1) begin bad++; $display("FAIL bp_reopen: got %b want 1", gbus.bus_rdy); end
            end
            tick();
            if (k == 1) gbus.bus_valid = 0;
        end
        total++; if (gbus.pe_ifmap_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", gbus.pe_ifmap_valid); end
    endtask

    task automatic test_drain();
        do_reset();
        start_session(3'd0, 8'd0);
        gbus.bus_valid = 1; gbus.bus_sel = 2'd0; gbus.bus_tag = 3'd0;
        gbus.bus_ifmap_data = 16'h00A1; tick();
        gbus.bus_ifmap_data = 16'h00A2; tick();
        gbus.bus_valid = 0; gbus.caster_en = 0;
        tick();
        gbus.bus_valid = 1; gbus.bus_ifmap_data = 16'h00A3;
        #1;
        total++; if (gbus.bus_rdy !== 1'b0) begin bad++; $display("FAIL drain_rdy: got %b want 0", gbus.bus_rdy); end
        tick(); tick();
        total++; if (gbus.busy !== 1'b1) begin bad++; $display("FAIL drain_hold: got %b want 1", gbus.busy); end
        gbus.pe_ifmap_ready = 1;
        tick();
        total++; if (gbus.pe_ifmap_data !== 16'h00A2 || gbus.busy !== 1'b1) begin
            bad++; $display("FAIL drain_pop1: got d=%h busy=%b want a2/1", gbus.pe_ifmap_data, gbus.busy); end
        tick();
        total++; if (gbus.pe_ifmap_valid !== 1'b0 || gbus.busy !== 1'b1) begin
            bad++; $display("FAIL drain_pop2: got v=%b busy=%b want 0/1", gbus.pe_ifmap_valid, gbus.busy); end
        tick();
        total++; if (gbus.busy !== 1'b0) begin bad++; $display("FAIL drain_fall: got %b want 0", gbus.busy); end
        gbus.bus_valid = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_session(3'd1, 8'd0);
        gbus.bus_valid = 1; gbus.bus_sel = 2'd2; gbus.bus_tag = 3'd1;
        for (int i = 0; i < 3; i++) begin
            gbus.bus_psum_data = 32'hC0DE0000 + 32'(i);
            tick();
        end
        #2;
        rstn = 0;
        idle_inputs();
        model_clear();
        #1;
        total++; if (gbus.pe_psum_valid !== 1'b0 || gbus.busy !== 1'b0 || gbus.pe_psum_data !== 32'h0) begin
            bad++; $display("FAIL midrst: got v=%b busy=%b d=%h want 0/0/0", gbus.pe_psum_valid, gbus.busy, gbus.pe_psum_data); end
        @(negedge clk);
        rstn = 1;
        @(posedge clk);
        #1;
        gbus.cfg_id = 3'd1; gbus.caster_en = 1;
        gbus.pe_ifmap_ready = 1; gbus.pe_fltr_ready = 1; gbus.pe_psum_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if ({gbus.pe_ifmap_valid, gbus.pe_fltr_valid, gbus.pe_psum_valid} !== 3'b000) begin
                bad++; $display("FAIL midrst_stale%0d: got %b want 000", i, {gbus.pe_ifmap_valid, gbus.pe_fltr_valid, gbus.pe_psum_valid}); end
        end
    endtask

    task automatic test_random(input logic [IW-1:0] id, input int cycles);
        logic [15:0] e_if, e_fl;
        logic [31:0] e_ps;
        do_reset();
        gbus.cfg_id = id;
        for (int c = 0; c < cycles; c++) begin
            if ($urandom_range(15) == 0) gbus.caster_en = ~gbus.caster_en;
            gbus.kernel_size    = 8'($urandom_range(5));
            gbus.bus_valid      = 1'($urandom_range(3) != 0);
            gbus.bus_sel        = 2'($urandom_range(3));
            gbus.bus_tag        = ($urandom_range(2) == 0) ? id : IW'($urandom_range(7));
            gbus.bus_ifmap_data = 16'($urandom);
            gbus.bus_fltr_data  = 16'($urandom);
            gbus.bus_psum_data  = $urandom;
            gbus.pe_ifmap_ready = 1'($urandom_range(1));
            gbus.pe_fltr_ready  = 1'($urandom_range(1));
            gbus.pe_psum_ready  = 1'($urandom_range(2) == 0);
            gbus.pe_fltr_clr    = 1'($urandom_range(7) == 0);
            #1;
            total++; if (gbus.bus_rdy !== m_rdy()) begin bad++; $display("FAIL rnd_rdy c%0d: got %b want %b", c, gbus.bus_rdy, m_rdy()); end
            tick();
            e_if = (q_if.size() > 0) ? q_if[0][15:0] : 16'h0;
            e_fl = (q_fl.size() > 0) ? q_fl[0][15:0] : 16'h0;
            e_ps = (q_ps.size() > 0) ? q_ps[0] : 32'h0;
            total++; if (gbus.pe_ifmap_valid !== (q_if.size() > 0) || gbus.pe_ifmap_data !== e_if) begin
                bad++; $display("FAIL rnd_ifmap c%0d: got v=%b d=%h want v=%b d=%h", c, gbus.pe_ifmap_valid, gbus.pe_ifmap_data, q_if.size() > 0, e_if); end
            total++; if (gbus.pe_fltr_valid !== (q_fl.size() > 0) || gbus.pe_fltr_data !== e_fl) begin
                bad++; $display("FAIL rnd_fltr c%0d: got v=%b d=%h want v=%b d=%h", c, gbus.pe_fltr_valid, gbus.pe_fltr_data, q_fl.size() > 0, e_fl); end
            total++; if (gbus.pe_psum_valid !== (q_ps.size() > 0) || gbus.pe_psum_data !== e_ps) begin
                bad++; $display("FAIL rnd_psum c%0d: got v=%b d=%h want v=%b d=%h", c, gbus.pe_psum_valid, gbus.pe_psum_data, q_ps.size() > 0, e_ps); end
            total++; if (gbus.busy !== (m_state != 0) || gbus.fltr_row_full !== m_row_full()) begin
                bad++; $display("FAIL rnd_ctl c%0d: got busy=%b full=%b want %b/%b", c, gbus.busy, gbus.fltr_row_full, m_state != 0, m_row_full()); end
        end
    endtask

    initial begin
        test_reset();
        test_tag_filter();
        test_broadcast();
        test_filter_row();
        test_backpressure();
        test_drain();
        test_reset_mid();
        test_random(3'd2, 600);
        test_random(3'd0, 600);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/glb_pe_caster.md
# glb_pe_caster

Per-PE multicast caster on the global PE bus. It sits between the global-buffer bus and one processing element. It accepts bus words whose TAG matches its configured ID, or the broadcast TAG, and steers each word into one of three per-stream FIFOs: ifmap, filter and psum. It gates filter loading to one kernel row of `kernel_size` words and drains cleanly when disabled.

## Interface
Parameters:
- DATA_WIDTH, 16, ifmap/filter word width; psum is 2*DATA_WIDTH
- NUM_COL, 4, PEs per bus; ID/TAG width IDW = $clog2(NUM_COL)+1
- FIFO_DEPTH, 4, entries per stream FIFO (power of two, ≥2)

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- caster_en  in  1  enable; rising edge starts a session
- cfg_id  in  IDW  this PE's ID; static while caster_en=1
- kernel_size  in  8  filter words per row; sampled on IDLE→ACTIVE
- bus_valid  in  1  bus word present
- bus_sel  in  2  0 ifmap, 1 filter, 2 psum, 3 reserved
- bus_tag  in  IDW  destination tag; all-ones = broadcast
- bus_ifmap_data  in  DATA_WIDTH  ifmap word
- bus_fltr_data  in  DATA_WIDTH  filter word
- bus_psum_data  in  2*DATA_WIDTH  psum word
- bus_rdy  out  1  this caster can accept the selected stream; upstream ANDs across targeted casters
- pe_ifmap_data / pe_ifmap_valid / pe_ifmap_ready  out/out/in  DATA_WIDTH/1/1  ifmap stream to PE
- pe_fltr_data / pe_fltr_valid / pe_fltr_ready  out/out/in  DATA_WIDTH/1/1  filter stream to PE
- pe_psum_data / pe_psum_valid / pe_psum_ready  out/out/in  2*DATA_WIDTH/1/1  psum stream to PE
- pe_fltr_clr  in  1  pulse: PE finished with the row; re-arms filter loading
- fltr_row_full  out  1  kernel_size filter words accepted this row
- busy  out  1  state ≠ IDLE

## Operation
- FSM states:
  - IDLE → ACTIVE when caster_en=1; latch kernel_size into ks_q and clear fltr_cnt.
  - ACTIVE → DRAIN when caster_en=0.
  - DRAIN → IDLE when all three FIFOs are empty.
  - In DRAIN, caster_en=1 does not skip the drain; it is evaluated again in IDLE.
- tag_match = (bus_tag==cfg_id) || (bus_tag=={IDW{1'b1}}).
- accept = state==ACTIVE && bus_valid && tag_match && bus_rdy.
- bus_rdy depends combinationally on bus_sel and state:
  - Low outside ACTIVE, and low for bus_sel=3.
  - Otherwise it is the selected FIFO's !full.
  - For filter, it additionally requires !fltr_row_full.
- bus_rdy is independent of bus_valid and bus_tag.
- On accept, only the selected stream's data bus is pushed; the other data buses are don't-care.
- Filter gating:
  - fltr_cnt (8 bit) increments on each accepted filter push.
  - fltr_row_full = (ks_q≠0) && (fltr_cnt==ks_q).
  - pe_fltr_clr sets fltr_cnt=0 and takes priority over a same-cycle increment; that filter word is still pushed.
  - ks_q=0 disables gating: unlimited filter accepts, fltr_row_full stays 0.
- The PE side is a plain valid/ready handshake per stream.
  - pe_*_valid = FIFO !empty; data is the FIFO head.
  - Pop happens on valid&&ready; ready with an empty FIFO is ignored.
- Psum width is preserved end to end; no arithmetic is applied to data.

## Timing
- Reset values: all FIFOs empty, all pe_*_valid=0, all pe_*_data=0, fltr_cnt=0, ks_q=0, fltr_row_full=0, busy=0, bus_rdy=0, state=IDLE.
- Reset asserted mid-operation discards FIFO contents immediately (asynchronous).
- Latency: a word accepted at edge N appears on pe_*_data with valid=1 after edge N, i.e. 1 cycle.
- Full FIFO: bus_rdy=0. Bus_rdy uses registered full only, so a same-cycle pop does not raise bus_rdy.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves its count unchanged.
- Pointers wrap modulo FIFO_DEPTH; full/empty are tracked with an extra pointer bit.
- busy rises 1 cycle after caster_en rises.
- busy falls 1 cycle after the last FIFO empties in DRAIN. With empty FIFOs, the state goes DRAIN→IDLE in 1 cycle.

## Structure
- Package glb_pkg holds:
  - typedef enum logic [1:0] {SEL_IFMAP, SEL_FLTR, SEL_PSUM, SEL_RSVD}
  - typedef enum {IDLE, ACTIVE, DRAIN}
  - function idw(NUM_COL) and the broadcast-tag constant
- Sub-module caster_fifo #(WIDTH, DEPTH): synchronous FIFO with push/pop/full/empty/head. It is instantiated three times, once per stream.

## Test plan
- Tag filter: cfg_id=2, push ifmap 0x1234 with tag 1, then tag 2 → only the second appears on pe_ifmap_data, 1 cycle after acceptance.
- Broadcast: tag=7 (NUM_COL=4), psum 0xDEADBEEF → pe_psum_valid=1 with data 0xDEADBEEF.
- Filter row: kernel_size=3, 4 filter words offered → 3 accepted, fltr_row_full=1 and bus_rdy=0 for bus_sel=1. After a pe_fltr_clr pulse, the 4th word is accepted.
- Full/backpressure: pe_ifmap_ready=0, 5 ifmap pushes with DEPTH=4 → bus_rdy drops after the 4th push. Releasing ready pops in FIFO order 1,2,3,4, then the 5th word is accepted.
- Drain: 2 words queued, caster_en dropped → bus_rdy=0, busy stays 1 until both are popped, then falls 1 cycle later.
- Reset mid-stream: rstn low with 3 queued words → all valids 0 and busy=0 immediately. After release, no stale data appears.
